// File: rtl/button_pkg.sv
// Shared constants for the push-button debouncer: FSM encoding, state width,
// default debounce/repeat timing and a counter-width helper.
package button_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE        = 2'd0;
    localparam logic [STATE_W-1:0] ST_ARM_PRESS   = 2'd1;
    localparam logic [STATE_W-1:0] ST_PRESSED     = 2'd2;
    localparam logic [STATE_W-1:0] ST_ARM_RELEASE = 2'd3;

    // 10 ms debounce, 500 ms first repeat, 200 ms cadence at 50 MHz
    localparam int DEF_DB_CYCLES     = 500000;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 10000000;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Signal bundle around one debounced button: raw pin in, clean level and strobes out.
interface button_debounce_if;

    logic button_raw;
    logic button_clean;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;

    // master drives the pin and consumes the strobes; slave is the debouncer side
    modport master (
        output button_raw,
        input  button_clean,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  button_raw,
        output button_clean,
        output press_pulse,
        output release_pulse,
        output repeat_pulse
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronized input, four-state stability FSM,
// registered clean level, press/release strobes and hold-to-repeat strobe.
module button_debounce
    import button_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic button_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W    = cnt_w(DB_CYCLES);
    localparam int DB_LAST = (DB_CYCLES >= 2) ? DB_CYCLES - 2 : 0;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_w(RPT_MAX);
    localparam bit RPT_EN  = (REPEAT_DELAY > 0);

    localparam logic [DB_W-1:0]  DB_LAST_V    = DB_W'(DB_LAST);
    localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);

    logic               s;
    logic [STATE_W-1:0] state_q, state_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
    logic               rpt_first_q, rpt_first_d;
    logic               clean_q, clean_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               repeat_q, repeat_d;
    logic [RPT_W-1:0]   rpt_term;
    logic [RPT_W-1:0]   rpt_val;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (button_raw),
        .q_o   (s)
    );

    // The IDLE/PRESSED exit edge is the first stable sample; an ARM state
    // accepts once its counter shows DB_CYCLES-2 further samples already taken.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (s) state_d = (DB_CYCLES <= 1) ? ST_PRESSED : ST_ARM_PRESS;
            end
            ST_ARM_PRESS: begin
                if (!s)                          state_d  = ST_IDLE;
                else if (db_cnt_q >= DB_LAST_V)  state_d  = ST_PRESSED;
                else                             db_cnt_d = db_cnt_q + 1'b1;
            end
            ST_PRESSED: begin
                if (!s) state_d = (DB_CYCLES <= 1) ? ST_IDLE : ST_ARM_RELEASE;
            end
            ST_ARM_RELEASE: begin
                if (s)                           state_d  = ST_PRESSED;
                else if (db_cnt_q >= DB_LAST_V)  state_d  = ST_IDLE;
                else                             db_cnt_d = db_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) db_cnt_d = '0;
    end

    assign clean_d   = (state_d == ST_PRESSED) || (state_d == ST_ARM_RELEASE);
    assign press_d   = clean_d & ~clean_q;
    assign release_d = ~clean_d & clean_q;

    // Repeat counter tallies cycles spent in PRESSED, saturating at the pending
    // threshold; a pulse due while in ARM_RELEASE waits for the return to PRESSED.
    assign rpt_term = rpt_first_q ? RPT_DELAY_V : RPT_PERIOD_V;
    assign rpt_val  = ((state_q == ST_PRESSED) && (rpt_cnt_q < rpt_term)) ?
                      rpt_cnt_q + 1'b1 : rpt_cnt_q;

    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        repeat_d    = 1'b0;
        if (!RPT_EN || (state_d != ST_PRESSED && state_d != ST_ARM_RELEASE)
            || state_q == ST_IDLE || state_q == ST_ARM_PRESS) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (state_d == ST_PRESSED && rpt_val >= rpt_term) begin
            repeat_d    = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
        end else begin
            rpt_cnt_d   = rpt_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            db_cnt_q    <= '0;
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
            clean_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
            clean_q     <= clean_d;
            press_q     <= press_d;
            release_q   <= release_d;
            repeat_q    <= repeat_d;
        end
    end

    assign button_clean  = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_button_debounce;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    button_debounce_if bus ();

    button_debounce #(
        .DB_CYCLES     (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .button_raw    (bus.button_raw),
        .button_clean  (bus.button_clean),
        .press_pulse   (bus.press_pulse),
        .release_pulse (bus.release_pulse),
        .repeat_pulse  (bus.repeat_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected vector order: {clean, press, release, repeat}
    task automatic check(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {bus.button_clean, bus.press_pulse, bus.release_pulse, bus.repeat_pulse};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.button_raw = 1'b0;
        step(); step(); step();
        check("reset", 4'b0000);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("idle %0d", i), 4'b0000);
        end

        // Clean press: accepted at edge 6, first repeat 10 cycles later
        bus.button_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("press k=%0d", k), {k >= 6, k == 6, 1'b0, k == 16});
        end

        // Release: repeat due at edge 21 still fires, clean falls at edge 6
        bus.button_raw = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            step();
            check($sformatf("release1 r=%0d", r), {r < 6, 1'b0, r == 6, r == 1});
        end

        // Bounce (low at edge 4), long hold, then a 2-cycle release glitch
        for (int e = 1; e <= 44; e++) begin
            bus.button_raw = (e == 4 || e == 33 || e == 34) ? 1'b0 : 1'b1;
            step();
            check($sformatf("hold e=%0d", e),
                  {e >= 10, e == 10, 1'b0,
                   (e == 20 || e == 25 || e == 30 || e == 37 || e == 42)});
        end

        bus.button_raw = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            step();
            check($sformatf("release2 r=%0d", r), {r < 6, 1'b0, r == 6, 1'b0});
        end

        // Reset while in ARM_PRESS with the stability count at 2
        bus.button_raw = 1'b1;
        for (int a = 1; a <= 5; a++) begin
            step();
            check($sformatf("arm a=%0d", a), 4'b0000);
        end
        reset = 1'b1;
        #1;
        check("reset in arm", 4'b0000);
        step(); step();
        check("reset held", 4'b0000);
        reset = 1'b0;
        for (int q = 1; q <= 10; q++) begin
            step();
            check($sformatf("post-reset q=%0d", q), {q >= 6, q == 6, 1'b0, 1'b0});
        end

        // Reset while PRESSED must not produce a release strobe
        reset = 1'b1;
        #1;
        check("reset in pressed", 4'b0000);
        bus.button_raw = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("after reset %0d", i), 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The parameter list SHALL contain only the following entries.
- DB_CYCLES, 500000: consecutive stable samples needed to accept a level change (10 ms at 50 MHz); legal range >= 1.
- REPEAT_DELAY, 25000000: cycles from an accepted press to the first repeat pulse; 0 disables auto-repeat.
- REPEAT_PERIOD, 10000000: cycles between later repeat pulses; legal range >= 1.
REQ-002 The port list SHALL be exactly the following, in this order.
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- button_raw, input, 1: asynchronous, bouncing push-button pin.
- button_clean, output, 1: debounced level; drives the button input of the display-scroll FSM.
- press_pulse, output, 1: one-cycle strobe on an accepted press.
- release_pulse, output, 1: one-cycle strobe on an accepted release.
- repeat_pulse, output, 1: one-cycle strobe while the button is held.

Function
REQ-003 button_raw SHALL pass through a two-flop synchronizer; the second flop's output is signal s, and no other logic SHALL sample button_raw directly.
REQ-004 The FSM SHALL have four states with these transitions.
- IDLE: clean=0; go to ARM_PRESS when s=1.
- ARM_PRESS: go back to IDLE when s=0.
- PRESSED: clean=1; go to ARM_RELEASE when s=0.
- ARM_RELEASE: go back to PRESSED when s=1.
REQ-005 The stability counter SHALL clear on every state change and increment once per cycle in ARM_PRESS and ARM_RELEASE.
REQ-006 A press SHALL be accepted at the DB_CYCLES-th consecutive edge sampling s=1, counting the IDLE-exit edge as the first.
REQ-007 A release SHALL be accepted at the DB_CYCLES-th consecutive edge sampling s=0, counting the PRESSED-exit edge as the first.
REQ-008 Total latency SHALL be exactly DB_CYCLES+2 rising edges from button_raw changing to the matching button_clean change, counting the first edge that samples the new value as edge 1.
REQ-009 press_pulse SHALL be high for exactly the one cycle in which button_clean first reads 1; release_pulse SHALL be high for exactly the one cycle in which button_clean first reads 0.
REQ-010 A raw glitch shorter than DB_CYCLES samples SHALL produce no change on any output, and an aborted ARM state SHALL produce no pulse.
REQ-011 With REPEAT_DELAY>0 and the FSM in PRESSED, the repeat counter SHALL count from 0 on entry to PRESSED.
- repeat_pulse fires REPEAT_DELAY cycles after press_pulse.
- Later repeat_pulse strobes follow every REPEAT_PERIOD cycles.
REQ-012 In ARM_RELEASE the repeat counter SHALL hold, and on a return to PRESSED it SHALL resume from the held value.
REQ-013 press_pulse, release_pulse and repeat_pulse SHALL be mutually exclusive within any cycle.
- repeat_pulse is never asserted in the press_pulse cycle.
- repeat_pulse is never asserted outside PRESSED.
REQ-014 All counters SHALL be sized to hold their parameter value without wrap and SHALL saturate rather than wrap.
REQ-015 All outputs SHALL be registered, with no combinational path from button_raw to any output.

Reset
REQ-016 reset SHALL asynchronously force the following, regardless of the current state.
- Both synchronizer flops to 0.
- FSM to IDLE.
- All counters to 0.
- button_clean, press_pulse, release_pulse and repeat_pulse to 0.
REQ-017 A reset asserted mid-ARM or mid-PRESSED SHALL emit no release_pulse.
REQ-018 If button_raw is high when reset deasserts, a normal press SHALL be accepted DB_CYCLES+2 edges later.

Structure
REQ-019 A shared package button_pkg SHALL hold the FSM state encoding, the state-width localparam, and the default debounce and repeat constants.
REQ-020 The synchronizer SHALL be a separate sub-module sync_2ff, with a 1-bit datapath and an asynchronous active-high reset to 0; all other logic SHALL live in button_debounce.

Verification
REQ-021 The bench SHALL use DB_CYCLES=4, REPEAT_DELAY=10 and REPEAT_PERIOD=5, and SHALL cover the following directed scenarios.
- Clean press: raw 0->1 held 20 cycles -> clean rises at edge 6; press_pulse high for exactly one cycle at edge 6.
- Bounce: raw high for 3 cycles, low for 1, then high steadily -> no pulse during the 3-cycle burst; a single press_pulse 6 edges after the final rise.
- Hold and repeat: raw high for 30 cycles -> repeat_pulse fires 10, 15, 20 cycles after press_pulse, one cycle each, never coincident with press_pulse.
- Release glitch: in PRESSED, raw low for 2 cycles then high -> clean stays 1, no release_pulse, and the repeat cadence shifts by the 2 held cycles.
- Release: raw 1->0 held -> clean falls 6 edges later with a single release_pulse.
- Reset in ARM_PRESS (count=2) -> all outputs 0 immediately; with raw still high after reset drops, press_pulse arrives 6 edges after deassertion.
